// File: rtl/pmem_arbiter.sv
// Round-robin arbiter: icache/dcache line requests onto one 64-bit burst pmem port; line <-> beat serialisation.
// Latency: request in IDLE -> pmem_read/write next cycle, resp the cycle after the last beat; pmem_resp=0 stalls the burst.
module pmem_arbiter #(
  parameter int BEAT_W      = 64,
  parameter int LINE_BEATS  = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_read,
  input  logic [31:0]                  i_address,
  output logic [BEAT_W*LINE_BEATS-1:0] i_rdata,
  output logic                         i_resp,
  input  logic                         d_read,
  input  logic                         d_write,
  input  logic [31:0]                  d_address,
  input  logic [BEAT_W*LINE_BEATS-1:0] d_wdata,
  output logic [BEAT_W*LINE_BEATS-1:0] d_rdata,
  output logic                         d_resp,
  output logic                         pmem_read,
  output logic                         pmem_write,
  output logic [31:0]                  pmem_address,
  output logic [BEAT_W-1:0]            pmem_wdata,
  input  logic [BEAT_W-1:0]            pmem_rdata,
  input  logic                         pmem_resp
);

  localparam int LINE_W = BEAT_W * LINE_BEATS;
  localparam int CNT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {ICACHE, DCACHE} req_t;

  state_t           state, state_nxt;
  req_t             last_grant, last_grant_nxt;
  req_t             owner, owner_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [31:0]      addr_q, addr_nxt;
  logic [LINE_W-1:0] asm_q, asm_nxt, rdata_q;
  logic             i_pend, d_pend, grant_d;
  logic             beat_fire, line_done;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      owner      <= ICACHE;
      count      <= '0;
      addr_q     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      count      <= count_nxt;
      addr_q     <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    count_nxt      = count;
    addr_nxt       = addr_q;
    grant_d        = 1'b0;
    beat_fire      = 1'b0;
    line_done      = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    i_resp         = 1'b0;
    d_resp         = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend || d_pend) begin
          // On contention the requester that did not win last time goes first.
          grant_d        = d_pend && (!i_pend || last_grant == ICACHE);
          owner_nxt      = grant_d ? DCACHE : ICACHE;
          last_grant_nxt = owner_nxt;
          count_nxt      = '0;
          addr_nxt       = (grant_d ? d_address : i_address) & ADDR_MASK;
          state_nxt      = (grant_d && d_write) ? WRITE : READ;
        end
      end
      READ, WRITE: begin
        pmem_read  = (state == READ);
        pmem_write = (state == WRITE);
        if (pmem_resp) begin
          beat_fire = 1'b1;
          count_nxt = count + CNT_W'(1);
          if (count == LAST_BEAT) begin
            line_done = (state == READ);
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        i_resp    = (owner == ICACHE);
        d_resp    = (owner == DCACHE);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[BEAT_W*count +: BEAT_W] = pmem_rdata;
  end

  // Beats assemble in asm_q; the visible line only changes when a read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q   <= '0;
      rdata_q <= '0;
    end else if (state == READ && beat_fire) begin
      asm_q <= asm_nxt;
      if (line_done) rdata_q <= asm_nxt;
    end
  end

  always_comb begin
    pmem_wdata = '0;
    if (state == WRITE) pmem_wdata = d_wdata[BEAT_W*count +: BEAT_W];
  end

  assign pmem_address = addr_q;
  assign i_rdata      = rdata_q;
  assign d_rdata      = rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: reads, writes, arbitration order, stalled beats, mid-burst reset.
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;

  int total = 0;
  int bad   = 0;

  pmem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] data);
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    step();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [63:0]  wexp [4];
  logic [63:0]  gbeat [4];
  int           pat [7];
  logic [255:0] gline;

  initial begin
    rst = 1'b0; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
    wexp  = '{64'hA, 64'hB, 64'hC, 64'hD};
    gbeat = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
    pat   = '{1, 0, 0, 1, 1, 0, 1};
    gline = {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
             64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

    // Reset state
    step();
    chk("rst_pmem_read",  pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_pmem_addr",  pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    chk("rst_i_resp",     i_resp, 0);
    chk("rst_d_resp",     d_resp, 0);
    chk("rst_i_rdata",    i_rdata, 0);
    chk("rst_d_rdata",    d_rdata, 0);
    rst = 1'b1;
    step();

    // Single icache read, back-to-back beats
    i_read = 1; i_address = 32'h0000_1234;
    chk("t1_c0_read", pmem_read, 0);
    step();
    chk("t1_c1_read", pmem_read, 1);
    chk("t1_addr", pmem_address, 32'h0000_1220);
    beat(64'h1111_1111_1111_1111);
    beat(64'h2222_2222_2222_2222);
    beat(64'h3333_3333_3333_3333);
    chk("t1_c4_resp", i_resp, 0);
    beat(64'h4444_4444_4444_4444);
    chk("t1_c5_i_resp", i_resp, 1);
    chk("t1_c5_d_resp", d_resp, 0);
    chk("t1_c5_read", pmem_read, 0);
    chk("t1_line", i_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    i_read = 0;
    step();
    chk("t1_c6_i_resp", i_resp, 0);

    // Dcache write
    d_write = 1; d_address = 32'h0000_5678; d_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
    step();
    chk("t2_addr", pmem_address, 32'h0000_5660);
    for (int k = 0; k < 4; k++) begin
      pmem_resp = 1'b1;
      chk("t2_write", pmem_write, 1);
      chk("t2_read", pmem_read, 0);
      chk("t2_wdata", pmem_wdata, wexp[k]);
      chk("t2_no_resp", d_resp, 0);
      step();
      pmem_resp = 1'b0;
    end
    chk("t2_d_resp", d_resp, 1);
    chk("t2_i_resp", i_resp, 0);
    chk("t2_done_write", pmem_write, 0);
    chk("t2_done_wdata", pmem_wdata, 0);
    d_write = 0;
    step();
    chk("t2_resp_clear", d_resp, 0);

    // Simultaneous requests after reset: dcache first, then icache
    do_reset();
    i_read = 1; i_address = 32'h0000_1234;
    d_read = 1; d_address = 32'h0000_5678;
    step();
    chk("t3_first_addr", pmem_address, 32'h0000_5660);
    chk("t3_first_read", pmem_read, 1);
    beat(64'h1); beat(64'h2); beat(64'h3); beat(64'h4);
    chk("t3_first_d_resp", d_resp, 1);
    chk("t3_first_i_resp", i_resp, 0);
    chk("t3_first_line", d_rdata, {64'h4, 64'h3, 64'h2, 64'h1});
    d_read = 0;
    step();
    chk("t3_idle_read", pmem_read, 0);
    step();
    chk("t3_second_addr", pmem_address, 32'h0000_1220);
    beat(64'h5); beat(64'h6); beat(64'h7); beat(64'h8);
    chk("t3_second_i_resp", i_resp, 1);
    chk("t3_second_d_resp", d_resp, 0);
    i_read = 0;
    step();
    i_read = 1; d_read = 1;
    step();
    chk("t3_third_addr", pmem_address, 32'h0000_5660);
    beat(64'h9); beat(64'hA); beat(64'hB); beat(64'hC);
    chk("t3_third_d_resp", d_resp, 1);
    d_read = 0;
    step();
    step();
    chk("t3_fourth_addr", pmem_address, 32'h0000_1220);
    beat(64'h9); beat(64'hA); beat(64'hB); beat(64'hC);
    chk("t3_fourth_i_resp", i_resp, 1);
    i_read = 0;
    step();

    // Read with pmem_resp gaps
    i_read = 1; i_address = 32'h0000_205F;
    step();
    chk("t4_addr", pmem_address, 32'h0000_2040);
    begin
      int j;
      j = 0;
      for (int k = 0; k < 7; k++) begin
        pmem_resp  = (pat[k] == 1);
        pmem_rdata = (pat[k] == 1) ? gbeat[j] : 64'hDEAD_BEEF_DEAD_BEEF;
        chk("t4_read_held", pmem_read, 1);
        chk("t4_no_early_resp", i_resp, 0);
        if (pat[k] == 1) j++;
        step();
      end
    end
    pmem_resp = 0; pmem_rdata = '0;
    chk("t4_i_resp", i_resp, 1);
    chk("t4_line", i_rdata, gline);
    i_read = 0;
    step();

    // d_read and d_write together act as a write
    d_read = 1; d_write = 1; d_address = 32'h0000_8000;
    d_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
    step();
    chk("t5_write", pmem_write, 1);
    chk("t5_read", pmem_read, 0);
    chk("t5_wdata0", pmem_wdata, 64'h1);
    beat(64'hBAD0); beat(64'hBAD1); beat(64'hBAD2); beat(64'hBAD3);
    chk("t5_d_resp", d_resp, 1);
    chk("t5_d_rdata_held", d_rdata, gline);
    d_read = 0; d_write = 0;
    step();

    // Reset during beat 2 of a dcache write
    d_write = 1; d_address = 32'h0000_9000; d_wdata = {64'h44, 64'h33, 64'h22, 64'h11};
    step();
    beat(64'h0); beat(64'h0);
    chk("t6_beat2_wdata", pmem_wdata, 64'h33);
    rst = 1'b0;
    #1;
    chk("t6_rst_write", pmem_write, 0);
    chk("t6_rst_wdata", pmem_wdata, 0);
    chk("t6_rst_addr", pmem_address, 0);
    chk("t6_rst_line", d_rdata, 0);
    d_write = 0;
    step();
    chk("t6_no_d_resp", d_resp, 0);
    rst = 1'b1;
    i_read = 1; i_address = 32'h0000_0040;
    step();
    chk("t6_i_granted", pmem_read, 1);
    chk("t6_i_addr", pmem_address, 32'h0000_0040);
    chk("t6_no_write", pmem_write, 0);
    beat(64'h1); beat(64'h2); beat(64'h3); beat(64'h4);
    chk("t6_i_resp", i_resp, 1);
    chk("t6_d_resp", d_resp, 0);
    i_read = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits between the CPU's two cacheline requesters (instruction cache, data cache) and the single 64-bit burst physical-memory port at the mp3 top level.
- Grants the memory port to one cache at a time using round-robin priority.
- Serialises each 256-bit line transfer into LINE_BEATS 64-bit beats, assembles read lines, and returns a one-cycle response to the granted cache.

Parameters:
- BEAT_W, 64, width of one pmem beat in bits.
- LINE_BEATS, 4, beats per cacheline. Line width is BEAT_W*LINE_BEATS = 256.
- OFFSET_BITS, 5, low address bits forced to zero on pmem_address (32-byte line).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_read  in  1  icache line-read request.
- i_address  in  32  icache line address.
- i_rdata  out  256  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line-read request.
- d_write  in  1  dcache line-write request.
- d_address  in  32  dcache line address.
- d_wdata  in  256  dcache line to write.
- d_rdata  out  256  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  32  burst line address, low OFFSET_BITS = 0.
- pmem_wdata  out  64  current write beat.
- pmem_rdata  in  64  current read beat.
- pmem_resp  in  1  one beat accepted/returned this cycle.

Behaviour:
- Reset (rst=0, asynchronous) forces immediately:
  - state=IDLE, beat count=0, last_grant=ICACHE.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - i_resp=0, d_resp=0.
  - Line buffer cleared, so i_rdata=d_rdata=0.
- Requester contract: request and address (and d_wdata) are held stable until the matching resp. The requester deasserts the request in the cycle after resp.
- States:
  - IDLE:
    - Only i_read pending: grant ICACHE.
    - Only d_read or d_write pending: grant DCACHE.
    - Both pending: grant the requester that is not last_grant.
    - On grant: latch requester id and address (low bits zeroed), set count=0, update last_grant, go to READ or WRITE.
    - No request pending: stay in IDLE.
  - READ:
    - pmem_read=1 and pmem_address=latched address for the whole burst.
    - Each cycle with pmem_resp=1: store pmem_rdata into line slice [BEAT_W*count +: BEAT_W], then count++.
    - On the beat where count==LINE_BEATS-1: go to DONE.
  - WRITE:
    - pmem_write=1, pmem_address=latched address.
    - pmem_wdata = d_wdata[BEAT_W*count +: BEAT_W] (combinational on count).
    - count++ on each pmem_resp; after the last beat go to DONE.
  - DONE:
    - Exactly one cycle: assert the granted requester's resp=1.
    - pmem_read=pmem_write=0.
    - The assembled line drives both i_rdata and d_rdata (valid in the resp cycle, held until the next read completes).
    - Next state IDLE.
- Beats need not be consecutive; pmem_resp=0 cycles stall count with no other effect.
- pmem_resp in IDLE or DONE is ignored.
- d_read and d_write both set: treat as a write.
- Requests arriving mid-burst wait. No preemption; a new grant is evaluated only in IDLE.
- Minimum latency: a request seen in IDLE at cycle 0 gives pmem_read/write=1 from cycle 1. With back-to-back pmem_resp on cycles 1-4, resp is asserted in cycle 5.
- pmem_wdata=0 outside WRITE.
- Reset asserted mid-burst aborts the burst immediately. No resp is issued for it, and the first request after reset is arbitrated fresh.

Test Plan:
- Single icache read, addr 0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. on consecutive pmem_resp:
  - pmem_address=0x0000_1220.
  - i_rdata[63:0]=beat0 … [255:192]=beat3.
  - i_resp single pulse in cycle 5; d_resp stays 0.
- Dcache write, d_wdata = {64'hD,64'hC,64'hB,64'hA}:
  - pmem_write=1.
  - pmem_wdata sequence A,B,C,D across the four pmem_resp.
  - d_resp one pulse; pmem_read stays 0.
- i_read and d_read raised in the same cycle after reset: dcache served first; icache granted in the IDLE after dcache DONE. Repeating the same simultaneous requests serves icache then dcache alternately.
- Read with pmem_resp gaps (pattern 1,0,0,1,1,0,1): line assembled correctly; count advances only on resp cycles.
- rst pulled low during beat 2 of a dcache write: pmem_write drops to 0 asynchronously, no d_resp. After release with i_read pending, icache is granted normally.
- d_read=d_write=1 simultaneously: performs a write burst; d_rdata unchanged from its prior value.
